// File: rtl/timer_pkg.sv
// Shared types and constants for the minutes/seconds timer controller.
package timer_pkg;

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] MAX_SEC = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Presets above 59 clamp to 59 so the counters never leave their legal range.
  function automatic logic [CNT_W-1:0] sat59(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v > MAX_SEC) r = MAX_SEC;
    else             r = v;
    return r;
  endfunction

endpackage

// File: rtl/timer_controller_mod60.sv
// Loadable up/down modulo-60 counter; wrap flags the step that crosses 59<->0.
module mod60_counter
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] q,
  output logic             wrap
);

  logic [CNT_W-1:0] r_q;
  logic [CNT_W-1:0] w_q_nxt;

  // Next count: load wins over stepping.
  always_comb begin
    w_q_nxt = r_q;
    if (load) begin
      w_q_nxt = load_val;
    end else if (en) begin
      if (up) w_q_nxt = (r_q >= MAX_SEC) ? 6'd0 : r_q + 6'd1;
      else    w_q_nxt = (r_q == 6'd0) ? MAX_SEC : r_q - 6'd1;
    end else begin
      w_q_nxt = r_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_q <= 6'd0;
    else       r_q <= w_q_nxt;
  end

  assign wrap = en & (up ? (r_q == MAX_SEC) : (r_q == 6'd0));
  assign q    = r_q;

endmodule

// File: rtl/timer_controller.sv
// Run/pause/clear/load sequencer with 1 Hz prescaler driving cascaded
// seconds/minutes counters in count-up or countdown mode.
module timer_controller
  import timer_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_stop,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_min,
  input  logic [CNT_W-1:0] load_sec,
  input  logic             mode,
  output logic [CNT_W-1:0] sec,
  output logic [CNT_W-1:0] min,
  output logic             running,
  output logic             done,
  output logic             tick,
  output logic             rollover
);

  localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_presc, w_presc_nxt;
  logic             r_mode;
  logic             r_running, r_done, r_tick, r_rollover;

  logic             w_ss, w_load, w_cnt_load, w_upd;
  logic             w_zero, w_one, w_sec_wrap, w_min_wrap;
  logic [CNT_W-1:0] w_sec_q, w_min_q, w_ld_sec, w_ld_min;

  // clear > load > start_stop; load is also dropped while running.
  assign w_ss       = start_stop & ~clear & ~load;
  assign w_load     = load & ~clear & (r_state != ST_RUN);
  assign w_cnt_load = clear | w_load;
  assign w_upd      = (r_state == ST_RUN) && (r_presc == PRESC_MAX);
  assign w_zero     = (w_sec_q == 6'd0) && (w_min_q == 6'd0);
  assign w_one      = (w_sec_q == 6'd1) && (w_min_q == 6'd0);
  assign w_ld_sec   = clear ? 6'd0 : sat59(load_sec);
  assign w_ld_min   = clear ? 6'd0 : sat59(load_min);

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    if (clear || w_load) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ss) w_state_nxt = (!mode && w_zero) ? ST_DONE : ST_RUN;
          else      w_state_nxt = ST_IDLE;
        end
        ST_RUN: begin
          if (w_upd && !r_mode && w_one) w_state_nxt = ST_DONE;
          else if (w_ss)                 w_state_nxt = ST_PAUSE;
          else                           w_state_nxt = ST_RUN;
        end
        ST_PAUSE: begin
          if (w_ss) w_state_nxt = ST_RUN;
          else      w_state_nxt = ST_PAUSE;
        end
        ST_DONE:  w_state_nxt = ST_DONE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Prescaler: only advances in RUN, so pausing keeps the sub-second phase.
  always_comb begin
    w_presc_nxt = r_presc;
    if (w_cnt_load) begin
      w_presc_nxt = '0;
    end else if (r_state == ST_IDLE) begin
      w_presc_nxt = '0;
    end else if (r_state == ST_RUN) begin
      w_presc_nxt = (r_presc == PRESC_MAX) ? '0 : r_presc + PW'(1);
    end else begin
      w_presc_nxt = r_presc;
    end
  end

  // State, prescaler, latched mode and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_presc    <= '0;
      r_mode     <= 1'b0;
      r_running  <= 1'b0;
      r_done     <= 1'b0;
      r_tick     <= 1'b0;
      r_rollover <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_presc    <= w_presc_nxt;
      r_mode     <= ((w_state_nxt == ST_RUN) && (r_state != ST_RUN)) ? mode : r_mode;
      r_running  <= (w_state_nxt == ST_RUN);
      r_done     <= (w_state_nxt == ST_DONE);
      r_tick     <= w_upd & ~clear;
      r_rollover <= w_upd & ~clear & r_mode & w_min_wrap;
    end
  end

  mod60_counter u_sec (
    .clk      (clk),
    .reset    (reset),
    .en       (w_upd),
    .up       (r_mode),
    .load     (w_cnt_load),
    .load_val (w_ld_sec),
    .q        (w_sec_q),
    .wrap     (w_sec_wrap)
  );

  mod60_counter u_min (
    .clk      (clk),
    .reset    (reset),
    .en       (w_sec_wrap),
    .up       (r_mode),
    .load     (w_cnt_load),
    .load_val (w_ld_min),
    .q        (w_min_q),
    .wrap     (w_min_wrap)
  );

  assign sec      = w_sec_q;
  assign min      = w_min_q;
  assign running  = r_running;
  assign done     = r_done;
  assign tick     = r_tick;
  assign rollover = r_rollover;

endmodule

// File: tb/tb_timer_controller.sv
// Directed bench for timer_controller with CLK_HZ=4 and hand-computed expectations.
module tb_timer_controller;

  logic       clk = 1'b0;
  logic       reset, start_stop, clear, load, mode;
  logic [5:0] load_min, load_sec;
  logic [5:0] sec, min;
  logic       running, done, tick, rollover;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  timer_controller #(.CLK_HZ(4)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .load(load),
    .load_min(load_min), .load_sec(load_sec), .mode(mode),
    .sec(sec), .min(min), .running(running), .done(done), .tick(tick), .rollover(rollover)
  );

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int m, input int s);
    chk({tag, ".min"}, 32'(min), 32'(m));
    chk({tag, ".sec"}, 32'(sec), 32'(s));
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1; cyc(1); start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; cyc(1); clear = 1'b0;
  endtask

  task automatic do_load(input logic [5:0] m, input logic [5:0] s);
    load_min = m; load_sec = s; load = 1'b1; cyc(1); load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_stop = 1'b0; clear = 1'b0; load = 1'b0; mode = 1'b1;
    load_min = 6'd0; load_sec = 6'd0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    chk_time("reset", 0, 0);
    chk("reset.running", 32'(running), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.tick", 32'(tick), 32'd0);
    chk("reset.rollover", 32'(rollover), 32'd0);

    // forward count: first update 4 cycles after RUN entry
    pulse_ss();
    chk("fwd.running", 32'(running), 32'd1);
    cyc(3);
    chk_time("fwd.c3", 0, 0);
    chk("fwd.c3.tick", 32'(tick), 32'd0);
    cyc(1);
    chk_time("fwd.c4", 0, 1);
    chk("fwd.c4.tick", 32'(tick), 32'd1);
    cyc(1);
    chk("fwd.c5.tick", 32'(tick), 32'd0);
    cyc(235);
    chk_time("fwd.c240", 1, 0);
    chk("fwd.c240.tick", 32'(tick), 32'd1);
    pulse_clear();
    chk_time("fwd.clear", 0, 0);
    chk("fwd.clear.running", 32'(running), 32'd0);

    // countdown 00:02 -> DONE
    mode = 1'b0;
    do_load(6'd0, 6'd2);
    chk_time("cd.load", 0, 2);
    pulse_ss();
    chk("cd.running", 32'(running), 32'd1);
    cyc(4);
    chk_time("cd.c4", 0, 1);
    cyc(4);
    chk_time("cd.c8", 0, 0);
    chk("cd.c8.done", 32'(done), 32'd1);
    chk("cd.c8.running", 32'(running), 32'd0);
    chk("cd.c8.tick", 32'(tick), 32'd1);
    pulse_ss();
    cyc(5);
    chk("cd.ss_ignored.done", 32'(done), 32'd1);
    chk("cd.ss_ignored.running", 32'(running), 32'd0);
    chk_time("cd.held", 0, 0);
    pulse_clear();
    chk("cd.clear.done", 32'(done), 32'd0);
    chk("cd.clear.running", 32'(running), 32'd0);

    // forward wrap 59:58 -> 59:59 -> 00:00 with rollover
    mode = 1'b1;
    do_load(6'd59, 6'd58);
    pulse_ss();
    cyc(4);
    chk_time("wrap.c4", 59, 59);
    chk("wrap.c4.rollover", 32'(rollover), 32'd0);
    cyc(4);
    chk_time("wrap.c8", 0, 0);
    chk("wrap.c8.rollover", 32'(rollover), 32'd1);
    chk("wrap.c8.running", 32'(running), 32'd1);
    cyc(1);
    chk("wrap.c9.rollover", 32'(rollover), 32'd0);
    chk("wrap.c9.running", 32'(running), 32'd1);
    pulse_clear();

    // pause after 2 RUN cycles, resume: update 2 cycles later
    pulse_ss();
    cyc(1);
    pulse_ss();
    chk("pause.running", 32'(running), 32'd0);
    cyc(10);
    chk_time("pause.frozen", 0, 0);
    chk("pause.tick", 32'(tick), 32'd0);
    pulse_ss();
    chk("resume.running", 32'(running), 32'd1);
    cyc(1);
    chk_time("resume.r1", 0, 0);
    cyc(1);
    chk_time("resume.r2", 0, 1);
    chk("resume.r2.tick", 32'(tick), 32'd1);
    pulse_clear();

    // priority and saturation
    do_load(6'd5, 6'd5);
    pulse_ss();
    cyc(4);
    clear = 1'b1; load = 1'b1; start_stop = 1'b1; load_min = 6'd7; load_sec = 6'd7;
    cyc(1);
    clear = 1'b0; load = 1'b0; start_stop = 1'b0;
    chk_time("prio", 0, 0);
    chk("prio.running", 32'(running), 32'd0);
    do_load(6'd63, 6'd60);
    chk_time("sat", 59, 59);
    pulse_ss();
    do_load(6'd1, 6'd1);
    chk_time("load_in_run", 59, 59);
    chk("load_in_run.running", 32'(running), 32'd1);
    pulse_clear();

    // mode change during RUN is deferred
    do_load(6'd0, 6'd10);
    pulse_ss();
    cyc(1);
    mode = 1'b0;
    cyc(3);
    chk_time("mode_latched", 0, 11);
    pulse_clear();
    mode = 1'b1;

    // async reset mid-RUN
    do_load(6'd12, 6'd34);
    pulse_ss();
    cyc(2);
    reset = 1'b1;
    #1;
    chk_time("async_rst", 0, 0);
    chk("async_rst.running", 32'(running), 32'd0);
    cyc(2);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("post_rst.tick", 32'(tick), 32'd0);
    end
    chk_time("post_rst", 0, 0);

    // countdown start at 00:00 goes straight to DONE
    mode = 1'b0;
    pulse_ss();
    chk("cd_zero.done", 32'(done), 32'd1);
    chk("cd_zero.running", 32'(running), 32'd0);
    pulse_clear();
    chk("cd_zero.clear.done", 32'(done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
